seq_arith_unit: RTL and testbench

//  Parametrised, clocked successor to the combinational arithmetic unit. Executes
//  one op (add/sub/mul/div/and/or/xor/not) per transaction on WIDTH-bit operands.
//  Mul and div are multi-cycle (shift-add / restoring). Valid/ready handshakes on

---
 rtl/seq_arith_unit.sv | 163 ++++++++++++++++
 tb/tb_seq_arith_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// Clocked arithmetic unit: add/sub/logic in one cycle, shift-add multiply and
// restoring divide over WIDTH cycles. Divider present only when SEQ_ARITH_DIV_EN is defined.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow,
  output logic               zero,
  output logic               err
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010,
                         OP_DIV = 3'b011, OP_AND = 3'b100, OP_OR  = 3'b101,
                         OP_XOR = 3'b110, OP_NOT = 3'b111;

  // Handshake: a command transfers on a rising edge where in_valid & in_ready;
  // a result transfers on a rising edge where out_valid & out_ready.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [2:0]    op_q;
  logic [CW-1:0] count_q;
  logic [WIDTH-1:0] mplr_q;
  logic [RW-1:0] mcand_q, prod_q, prod_nxt, iter_result;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle results, computed straight from the operands being accepted.
  logic [WIDTH:0]  sum, diff;
  logic [RW-1:0]   s_result;
  logic            s_ovf, s_err, s_multi;

  always_comb begin
    sum      = {1'b0, x} + {1'b0, y};
    diff     = {1'b0, x} - {1'b0, y};
    s_result = '0;
    s_ovf    = 1'b0;
    s_err    = 1'b0;
    s_multi  = 1'b0;
    case (op)
      OP_ADD: begin
        s_result = {{(WIDTH-1){1'b0}}, sum};
        s_ovf    = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        s_result = {{(WIDTH-1){1'b0}}, diff};
        s_ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      end
      OP_MUL: s_multi = 1'b1;
      OP_DIV: begin
`ifdef SEQ_ARITH_DIV_EN
        if (y == '0) begin
          s_result = {x, {WIDTH{1'b1}}};
          s_err    = 1'b1;
        end else begin
          s_multi = 1'b1;
        end
`else
        s_err = 1'b1;
`endif
      end
      OP_AND:  s_result = {{WIDTH{1'b0}}, x & y};
      OP_OR:   s_result = {{WIDTH{1'b0}}, x | y};
      OP_XOR:  s_result = {{WIDTH{1'b0}}, x ^ y};
      OP_NOT:  s_result = {{WIDTH{1'b0}}, ~x};
      default: s_result = '0;
    endcase
  end

  assign prod_nxt = prod_q + (mplr_q[0] ? mcand_q : '0);

`ifdef SEQ_ARITH_DIV_EN
  logic [WIDTH-1:0] quo_q, rem_q, div_q, rem_nxt, quo_nxt, rem_diff;
  logic [WIDTH:0]   rem_sh;
  logic             take;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    take     = (rem_sh >= {1'b0, div_q});
    rem_diff = rem_sh[WIDTH-1:0] - div_q;
    rem_nxt  = take ? rem_diff : rem_sh[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], take};
  end
  assign iter_result = (op_q == OP_DIV) ? {rem_nxt, quo_nxt} : prod_nxt;
`else
  assign iter_result = prod_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      count_q  <= '0;
      mplr_q   <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
`ifdef SEQ_ARITH_DIV_EN
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op;
          if (s_multi) begin
            state   <= BUSY;
            count_q <= '0;
            mplr_q  <= y;
            mcand_q <= {{WIDTH{1'b0}}, x};
            prod_q  <= '0;
`ifdef SEQ_ARITH_DIV_EN
            quo_q   <= x;
            rem_q   <= '0;
            div_q   <= y;
`endif
          end else begin
            state    <= DONE;
            result   <= s_result;
            overflow <= s_ovf;
            err      <= s_err;
            zero     <= (s_result == '0);
          end
        end
        BUSY: begin
          count_q <= count_q + 1'b1;
          mplr_q  <= mplr_q >> 1;
          mcand_q <= mcand_q << 1;
          prod_q  <= prod_nxt;
`ifdef SEQ_ARITH_DIV_EN
          quo_q   <= quo_nxt;
          rem_q   <= rem_nxt;
`endif
          if (count_q == CW'(WIDTH - 1)) begin
            state    <= DONE;
            result   <= iter_result;
            overflow <= (op_q == OP_MUL) && (iter_result[RW-1:WIDTH] != '0);
            err      <= 1'b0;
            zero     <= (iter_result == '0);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit (WIDTH=8): directed vectors plus random ops checked
// against an arithmetic reference model; follows SEQ_ARITH_DIV_EN like the RTL.
module tb_seq_arith_unit;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic [2:0]    op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic          overflow, zero, err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model straight from the arithmetic definition of each op.
  task automatic model(input logic [2:0] o, input int a, input int b,
                       output int res, output logic ovf, output logic e, output int lat);
    int s;
    ovf = 1'b0; e = 1'b0; lat = 1; res = 0;
    case (o)
      3'd0: begin res = a + b; s = to_signed(a) + to_signed(b); ovf = (s > 127 || s < -128); end
      3'd1: begin res = (a - b) & 'h1FF; s = to_signed(a) - to_signed(b); ovf = (s > 127 || s < -128); end
      3'd2: begin res = a * b; ovf = (res > 255); lat = W + 1; end
      3'd3: begin
`ifdef SEQ_ARITH_DIV_EN
        if (b == 0) begin res = (a << 8) | 255; e = 1'b1; end
        else begin res = ((a % b) << 8) | (a / b); lat = W + 1; end
`else
        res = 0; e = 1'b1;
`endif
      end
      3'd4: res = a & b;
      3'd5: res = a | b;
      3'd6: res = a ^ b;
      default: res = (~a) & 255;
    endcase
  endtask

  // Issue one command, measure latency, check result, hold in DONE, hand off.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input int want);
    int e_res, e_lat, lat;
    logic e_ovf, e_err, busy_ok;
    logic [2*W-1:0] e_r;
    model(o, int'(a), int'(b), e_res, e_ovf, e_err, e_lat);
    exp_q.push_back(e_res[2*W-1:0]);
    check("in_ready_before_issue", in_ready, 1);
    in_valid = 1'b1; op = o; x = a; y = b;
    tick();
    in_valid = 1'b0; x = W'($urandom); y = W'($urandom); op = 3'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    e_r = exp_q.pop_front();
    check("out_valid_seen", out_valid, 1);
    check("latency", lat, e_lat);
    check("in_ready_low_while_busy", busy_ok, 1);
    check("result", result, e_r);
    check("overflow", overflow, e_ovf);
    check("zero", zero, (e_r == 0));
    check("err", err, e_err);
    if (want >= 0) check("result_vector", result, want);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; x = W'($urandom); y = W'($urandom);
      tick();
      check("hold_result_stable", {err, zero, overflow, result}, {e_err, (e_r == 0), e_ovf, e_r});
      check("hold_in_ready_low", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_out_valid_low", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", {overflow, zero, err}, 0);

    run_op(3'd0, 8'd100, 8'd100, 0, 'h00C8);
    run_op(3'd1, 8'd5,   8'd7,   0, 'h01FE);
    run_op(3'd2, 8'd255, 8'd255, 0, 'hFE01);
`ifdef SEQ_ARITH_DIV_EN
    run_op(3'd3, 8'd200, 8'd7,   0, 'h041C);
    run_op(3'd3, 8'h55,  8'd0,   0, 'h55FF);
`else
    run_op(3'd3, 8'd200, 8'd7,   0, 'h0000);
`endif
    run_op(3'd4, 8'hF0, 8'h3C, 0, 'h0030);
    run_op(3'd5, 8'hF0, 8'h0C, 0, 'h00FC);
    run_op(3'd6, 8'hFF, 8'hFF, 0, 'h0000);
    run_op(3'd7, 8'h0F, 8'h00, 0, 'h00F0);
    run_op(3'd1, 8'h80, 8'h01, 0, 'h007F);
    run_op(3'd2, 8'd13,  8'd11, 5, 'h008F);
    run_op(3'd0, 8'd7,   8'd9,  5, 'h0010);

    // Reset four cycles into a multiply abandons it.
    in_valid = 1'b1; op = 3'd2; x = 8'd200; y = 8'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_in_ready", in_ready, 1);
    rst = 1'b0;
    run_op(3'd0, 8'd3, 8'd4, 0, 'h0007);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] ro;
      logic [7:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(ro, ra, rb, $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
